// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions for the slave endpoint (and its spi_master peer).
// Contents:
//   SPI_MODE0..3   standard mode numbers, mode = {CPOL, CPHA}
//   spi_state_e    slave transaction state
//   mode_cpol()    CPOL bit of a mode number
//   mode_cpha()    CPHA bit of a mode number
package spi_slave_pkg;

  localparam int unsigned SPI_MODE0 = 0;
  localparam int unsigned SPI_MODE1 = 1;
  localparam int unsigned SPI_MODE2 = 2;
  localparam int unsigned SPI_MODE3 = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic int unsigned mode_cpol(input int unsigned mode);
    return (mode >> 1) & 32'd1;
  endfunction

  function automatic int unsigned mode_cpha(input int unsigned mode);
    return mode & 32'd1;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_sync: two-flop synchronizer for an asynchronous pin, with a third
// stage used only to derive single-clk rise/fall pulses.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset (stages load RST_VAL)
//   d_i     asynchronous input pin
//   q_o     synchronized level (after 2 flops)
//   rise_o  1-clk pulse when q_o goes 0->1
//   fall_o  1-clk pulse when q_o goes 1->0
module spi_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[0] is the metastability-catching stage, sync_q[2] the edge history.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral-side endpoint, oversampled in the clk domain.
// Deserialises MOSI into rx_data words and serialises a one-entry TX
// buffer onto MISO, MSB first, in any CPOL/CPHA mode.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   SCLK, CS, MOSI    asynchronous SPI pins (CS active low)
//   MISO, miso_oe     slave data out and its pad output enable
//   tx_data/valid/ready  one-entry TX buffer write handshake
//   rx_data, rx_valid last received word and 1-clk update pulse
//   busy              synchronized CS low
//   tx_underrun       1-clk pulse: word load found the TX buffer empty
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CPOL       = 0,
  parameter int unsigned CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Pin synchronizers
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(CPOL != 0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .q_o    (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (CS),
    .q_o    (cs_lvl_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (MOSI),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  // Edge classification
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign lead_edge   = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign trail_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  // State
  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  reload_q, reload_d;

  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    reload_d   = reload_q;
    load       = 1'b0;
    // A load always sees the buffer as it was before this clk's write.
    load_word  = buf_full_q ? buf_q : '0;

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        reload_d  = 1'b0;
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
          if (CPHA == 0) begin
            miso_d     = load_word[DATA_WIDTH-1];
            tx_shift_d = {load_word[DATA_WIDTH-2:0], 1'b0};
          end else begin
            tx_shift_d = load_word;
          end
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          // Abort: partial word and unsent bits are dropped, buffer kept.
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          miso_d     = 1'b0;
          reload_d   = 1'b0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              if (CPHA == 0) begin
                load       = 1'b1;
                miso_d     = load_word[DATA_WIDTH-1];
                tx_shift_d = {load_word[DATA_WIDTH-2:0], 1'b0};
              end else begin
                reload_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if ((CPHA != 0) && reload_q) begin
              load       = 1'b1;
              reload_d   = 1'b0;
              miso_d     = load_word[DATA_WIDTH-1];
              tx_shift_d = {load_word[DATA_WIDTH-2:0], 1'b0};
            end else if ((CPHA != 0) || (bit_cnt_q != '0)) begin
              // CPHA=0: a trailing edge with bit_cnt=0 follows the final
              // sample, whose reload already put the next MSB on MISO.
              miso_d     = tx_shift_q[DATA_WIDTH-1];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
    endcase

    if (load) begin
      if (buf_full_q) begin
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      reload_q   <= reload_d;
    end
  end

  assign MISO        = miso_q;
  assign miso_oe     = (state_q == ST_ACTIVE);
  assign busy        = (state_q == ST_ACTIVE);
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  import spi_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs, mosi, txv;
  logic [7:0] txd;
  logic [3:0] miso, oe, txr, rxv, busy, und;
  logic [7:0] rxd [4];

  int checks = 0;
  int errors = 0;
  int rxv_cnt [4] = '{0, 0, 0, 0};
  int und_cnt [4] = '{0, 0, 0, 0};

  always #10 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(
      .DATA_WIDTH (8),
      .CPOL       (mode_cpol(g)),
      .CPHA       (mode_cpha(g))
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .SCLK        (sclk[g]),
      .CS          (cs[g]),
      .MOSI        (mosi[g]),
      .MISO        (miso[g]),
      .miso_oe     (oe[g]),
      .tx_data     (txd),
      .tx_valid    (txv[g]),
      .tx_ready    (txr[g]),
      .rx_data     (rxd[g]),
      .rx_valid    (rxv[g]),
      .busy        (busy[g]),
      .tx_underrun (und[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rxv[i]) rxv_cnt[i] = rxv_cnt[i] + 1;
      if (und[i]) und_cnt[i] = und_cnt[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic write_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    txd    = d;
    txv[m] = 1'b1;
    @(negedge clk);
    txv[m] = 1'b0;
  endtask

  task automatic cs_assert(input int m);
    @(negedge clk);
    cs[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_release(input int m);
    repeat (8) @(negedge clk);
    cs[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Behavioural SPI master: drives MOSI MSB first, captures MISO per CPHA.
  task automatic xfer(input int m, input logic [7:0] w, input int nbits, output logic [7:0] got);
    logic c, h;
    c   = (mode_cpol(m) != 0);
    h   = (mode_cpha(m) != 0);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!h) begin
        mosi[m] = w[7-i];
        half();
        sclk[m] = ~c;
        got     = {got[6:0], miso[m]};
        half();
        sclk[m] = c;
      end else begin
        sclk[m] = ~c;
        mosi[m] = w[7-i];
        half();
        sclk[m] = c;
        got     = {got[6:0], miso[m]};
        half();
      end
    end
  endtask

  typedef struct {
    int unsigned mode;
    logic [7:0]  tx;
    logic [7:0]  mosi;
    logic [7:0]  exp_rx;
    logic [7:0]  exp_miso;
    int          exp_und;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int         m, brx, bun;

    vecs[0] = '{SPI_MODE0, 8'h3C, 8'hAC, 8'hAC, 8'h3C, 1};
    vecs[1] = '{SPI_MODE1, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 0};
    vecs[2] = '{SPI_MODE2, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 1};
    vecs[3] = '{SPI_MODE3, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 0};
    vecs[4] = '{SPI_MODE0, 8'hC3, 8'h01, 8'h01, 8'hC3, 1};
    vecs[5] = '{SPI_MODE3, 8'h80, 8'hFE, 8'hFE, 8'h80, 0};

    rst  = 1'b1;
    cs   = '1;
    mosi = '0;
    txv  = '0;
    txd  = '0;
    for (int i = 0; i < 4; i++) sclk[i] = (mode_cpol(i) != 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_miso_m%0d", i), miso[i], 0);
      chk($sformatf("rst_oe_m%0d", i), oe[i], 0);
      chk($sformatf("rst_txr_m%0d", i), txr[i], 1);
      chk($sformatf("rst_rxd_m%0d", i), rxd[i], 0);
      chk($sformatf("rst_rxv_m%0d", i), rxv[i], 0);
      chk($sformatf("rst_busy_m%0d", i), busy[i], 0);
      chk($sformatf("rst_und_m%0d", i), und[i], 0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single-word transfers across all modes
    for (int v = 0; v < 6; v++) begin
      m   = int'(vecs[v].mode);
      brx = rxv_cnt[m];
      bun = und_cnt[m];
      write_tx(m, vecs[v].tx);
      chk($sformatf("v%0d_txr_full", v), txr[m], 0);
      cs_assert(m);
      chk($sformatf("v%0d_busy", v), busy[m], 1);
      chk($sformatf("v%0d_oe", v), oe[m], 1);
      chk($sformatf("v%0d_txr_loaded", v), txr[m], 1);
      chk($sformatf("v%0d_und_at_cs", v), und_cnt[m] - bun, 0);
      xfer(m, vecs[v].mosi, 8, got);
      cs_release(m);
      chk($sformatf("v%0d_rx", v), rxd[m], vecs[v].exp_rx);
      chk($sformatf("v%0d_rxv_cnt", v), rxv_cnt[m] - brx, 1);
      chk($sformatf("v%0d_miso_word", v), got, vecs[v].exp_miso);
      chk($sformatf("v%0d_und_cnt", v), und_cnt[m] - bun, vecs[v].exp_und);
      chk($sformatf("v%0d_idle_busy", v), busy[m], 0);
      chk($sformatf("v%0d_idle_oe", v), oe[m], 0);
      chk($sformatf("v%0d_idle_miso", v), miso[m], 0);
    end

    // Two words in one CS assertion, second written after the first load
    brx = rxv_cnt[0];
    bun = und_cnt[0];
    write_tx(0, 8'h11);
    cs_assert(0);
    write_tx(0, 8'h22);
    chk("b2b_txr_full", txr[0], 0);
    xfer(0, 8'hC7, 8, got);
    chk("b2b_miso0", got, 8'h11);
    chk("b2b_rx0", rxd[0], 8'hC7);
    chk("b2b_rxv0", rxv_cnt[0] - brx, 1);
    xfer(0, 8'h3E, 8, got);
    chk("b2b_miso1", got, 8'h22);
    cs_release(0);
    chk("b2b_rx1", rxd[0], 8'h3E);
    chk("b2b_rxv1", rxv_cnt[0] - brx, 2);
    chk("b2b_und", und_cnt[0] - bun, 1);

    // Underrun: nothing written
    brx = rxv_cnt[0];
    bun = und_cnt[0];
    cs_assert(0);
    chk("urun_at_cs", und_cnt[0] - bun, 1);
    xfer(0, 8'h96, 8, got);
    chk("urun_miso", got, 8'h00);
    cs_release(0);
    chk("urun_rx", rxd[0], 8'h96);
    chk("urun_rxv", rxv_cnt[0] - brx, 1);
    chk("urun_cnt_end", und_cnt[0] - bun, 2);

    // CS raised after 5 bits; pending buffer word survives the abort
    brx = rxv_cnt[0];
    write_tx(0, 8'hA0);
    cs_assert(0);
    write_tx(0, 8'hE7);
    xfer(0, 8'hFF, 5, got);
    chk("abort_miso_bits", got, 8'h14);
    cs_release(0);
    chk("abort_no_rxv", rxv_cnt[0] - brx, 0);
    chk("abort_rx_held", rxd[0], 8'h96);
    chk("abort_buf_kept", txr[0], 0);
    cs_assert(0);
    chk("abort_next_load", txr[0], 1);
    xfer(0, 8'hF0, 8, got);
    cs_release(0);
    chk("abort_next_rx", rxd[0], 8'hF0);
    chk("abort_next_rxv", rxv_cnt[0] - brx, 1);
    chk("abort_next_miso", got, 8'hE7);

    // Reset mid-word
    write_tx(0, 8'h55);
    cs_assert(0);
    xfer(0, 8'h3C, 4, got);
    @(negedge clk);
    rst   = 1'b1;
    cs[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_miso", miso[0], 0);
    chk("mrst_oe", oe[0], 0);
    chk("mrst_txr", txr[0], 1);
    chk("mrst_rxd", rxd[0], 0);
    chk("mrst_rxv", rxv[0], 0);
    chk("mrst_busy", busy[0], 0);
    chk("mrst_und", und[0], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    brx = rxv_cnt[0];
    bun = und_cnt[0];
    write_tx(0, 8'h81);
    cs_assert(0);
    chk("post_rst_und", und_cnt[0] - bun, 0);
    xfer(0, 8'h81, 8, got);
    cs_release(0);
    chk("post_rst_rx", rxd[0], 8'h81);
    chk("post_rst_rxv", rxv_cnt[0] - brx, 1);
    chk("post_rst_miso", got, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
